// File: rtl/enc_16x4_scan.sv
// enc_16x4_scan: self-test scanner and 16-to-4 encoder for 4x16 decoders.
// The scanner steps {W,X,Y,Z} through all 16 codes, holding each one for
// SETTLE_CYC cycles. It then captures D_in and encodes it, and records any
// line whose response differs from the expected one-hot value.
// Optional build macro ENC_PRIORITY_EN: a multi-hot sample is resolved to its
// highest set bit (code_valid=1). Without the macro a multi-hot sample reports
// code_valid=0 and code_out=0.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last scan result
// DRIVE  | address held on W,X,Y,Z while the decoder settles
// SAMPLE | D_in captured
// CHECK  | capture encoded, fault recorded, address advanced
// FIN    | scan complete; done pulses in the following cycle
module enc_16x4_scan #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] D_in,
    output logic        W,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        busy,
    output logic        done,
    output logic [3:0]  code_out,
    output logic        code_valid,
    output logic        multi_hot,
    output logic [15:0] fault_map,
    output logic [4:0]  fault_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        CHECK  = 3'd3,
        FIN    = 3'd4
    } state_t;

    // The settle counter counts down to zero, so DRIVE lasts exactly SETTLE_CYC cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t      state;
    logic [3:0]  addr;
    logic [3:0]  settle_cnt;
    logic [15:0] cap;

    logic [3:0]  hi_idx;
    logic        any_set;
    logic        multi;
    logic        mismatch;

    assign {W, X, Y, Z} = addr;

    // Encode the captured value: highest set bit, any bit set, more than one bit set.
    always_comb begin
        hi_idx  = 4'd0;
        any_set = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (cap[i]) begin
                hi_idx  = 4'(i);
                any_set = 1'b1;
            end
        end
        multi    = (cap & (cap - 16'd1)) != 16'd0;
        mismatch = cap != (16'h0001 << addr);
    end

    // Scan sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= 4'd0;
            settle_cnt <= 4'd0;
            cap        <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            code_out   <= 4'd0;
            code_valid <= 1'b0;
            multi_hot  <= 1'b0;
            fault_map  <= 16'd0;
            fault_cnt  <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        fault_map  <= 16'd0;
                        fault_cnt  <= 5'd0;
                        code_out   <= 4'd0;
                        code_valid <= 1'b0;
                        multi_hot  <= 1'b0;
                        addr       <= 4'd0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    cap   <= D_in;
                    state <= CHECK;
                end
                CHECK: begin
                    multi_hot <= multi;
                    if (!any_set) begin
                        code_out   <= 4'd0;
                        code_valid <= 1'b0;
                    end else if (!multi) begin
                        code_out   <= hi_idx;
                        code_valid <= 1'b1;
                    end else begin
`ifdef ENC_PRIORITY_EN
                        code_out   <= hi_idx;
                        code_valid <= 1'b1;
`else
                        code_out   <= 4'd0;
                        code_valid <= 1'b0;
`endif
                    end
                    if (mismatch) begin
                        fault_map[addr] <= 1'b1;
                        fault_cnt       <= fault_cnt + 5'd1;
                    end
                    // Address 15 wraps to 0, so W,X,Y,Z are already back at 0 during FIN.
                    addr       <= addr + 4'd1;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= (addr == 4'd15) ? FIN : DRIVE;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    addr  <= 4'd0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    addr  <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_16x4_scan.sv
// tb_enc_16x4_scan: directed bench for enc_16x4_scan.
// The main instance has SETTLE_CYC=2 and a switchable faulty decoder model.
// Two more fault-free instances have SETTLE_CYC=1 and SETTLE_CYC=15.
module tb_enc_16x4_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_r = 1'b0;
    int   sel = 2;
    int   mode = 0;

    logic [15:0] d2, d1, d15;
    logic w2, x2, y2, z2, busy2, done2, cv2, mh2;
    logic w1, x1, y1, z1, busy1, done1, cv1, mh1;
    logic w15, x15, y15, z15, busy15, done15, cv15, mh15;
    logic [3:0] co2, co1, co15;
    logic [15:0] fm2, fm1, fm15;
    logic [4:0] fc2, fc1, fc15;
    logic start2, start1, start15;

    logic [3:0]  o_addr, o_co;
    logic        o_busy, o_done, o_cv, o_mh;
    logic [15:0] o_fm;
    logic [4:0]  o_fc;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    assign start2  = start_r && (sel == 2);
    assign start1  = start_r && (sel == 1);
    assign start15 = start_r && (sel == 15);

    // Decoder under test: mode 0 good, 1 = D[0] stuck-at-0, 2 = D[5] stuck-at-1.
    always_comb begin
        d2 = 16'h0001 << {w2, x2, y2, z2};
        if (mode == 1) d2[0] = 1'b0;
        else if (mode == 2) d2[5] = 1'b1;
        d1  = 16'h0001 << {w1, x1, y1, z1};
        d15 = 16'h0001 << {w15, x15, y15, z15};
    end

    enc_16x4_scan #(.SETTLE_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .D_in(d2),
        .W(w2), .X(x2), .Y(y2), .Z(z2), .busy(busy2), .done(done2),
        .code_out(co2), .code_valid(cv2), .multi_hot(mh2),
        .fault_map(fm2), .fault_cnt(fc2));

    enc_16x4_scan #(.SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .D_in(d1),
        .W(w1), .X(x1), .Y(y1), .Z(z1), .busy(busy1), .done(done1),
        .code_out(co1), .code_valid(cv1), .multi_hot(mh1),
        .fault_map(fm1), .fault_cnt(fc1));

    enc_16x4_scan #(.SETTLE_CYC(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .start(start15), .D_in(d15),
        .W(w15), .X(x15), .Y(y15), .Z(z15), .busy(busy15), .done(done15),
        .code_out(co15), .code_valid(cv15), .multi_hot(mh15),
        .fault_map(fm15), .fault_cnt(fc15));

    always_comb begin
        case (sel)
            1: begin
                o_addr = {w1, x1, y1, z1}; o_busy = busy1; o_done = done1;
                o_co = co1; o_cv = cv1; o_mh = mh1; o_fm = fm1; o_fc = fc1;
            end
            15: begin
                o_addr = {w15, x15, y15, z15}; o_busy = busy15; o_done = done15;
                o_co = co15; o_cv = cv15; o_mh = mh15; o_fm = fm15; o_fc = fc15;
            end
            default: begin
                o_addr = {w2, x2, y2, z2}; o_busy = busy2; o_done = done2;
                o_co = co2; o_cv = cv2; o_mh = mh2; o_fm = fm2; o_fc = fc2;
            end
        endcase
    end

    always @(negedge clk) if (o_done) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand-derived response of the encoder for address k under each fault model.
    task automatic expect_code(input int m, input int k, output logic [3:0] ec,
                               output logic ev, output logic emh);
        ec = 4'(k); ev = 1'b1; emh = 1'b0;
        if (m == 1 && k == 0) begin
            ec = 4'd0; ev = 1'b0;
        end
        if (m == 2 && k != 5) begin
            emh = 1'b1;
`ifdef ENC_PRIORITY_EN
            ec = (k > 5) ? 4'(k) : 4'd5; ev = 1'b1;
`else
            ec = 4'd0; ev = 1'b0;
`endif
        end
    endtask

    // hs: 0 = single start pulse, 1 = start held through FIN, 2 = extra pulse at a=9.
    task automatic run_scan(input int s, input int m, input int hs, input string nm);
        int per, total, base, k, j;
        logic [3:0] ec;
        logic ev, emh;
        logic [15:0] efm;
        logic [4:0] efc;
        per = s + 2;
        total = 16 * per;
        base = done_seen;
        efm = (m == 1) ? 16'h0001 : (m == 2) ? 16'hFFDF : 16'h0000;
        efc = (m == 1) ? 5'd1 : (m == 2) ? 5'd15 : 5'd0;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= total + 1; c++) begin
            @(negedge clk);
            if (hs != 1 || c == total + 1) start_r = 1'b0;
            if (hs == 2 && c == 9 * per + 1) start_r = 1'b1;
            k = c / per;
            j = c % per;
            if (c == 0) begin
                check({nm, " cleared fault_map"}, 32'(o_fm), 32'h0);
                check({nm, " cleared fault_cnt"}, 32'(o_fc), 32'h0);
                check({nm, " cleared code_valid"}, 32'(o_cv), 32'h0);
            end
            if (c > 0 && j == 0) begin
                expect_code(m, k - 1, ec, ev, emh);
                check($sformatf("%s a=%0d code_out", nm, k - 1), 32'(o_co), 32'(ec));
                check($sformatf("%s a=%0d code_valid", nm, k - 1), 32'(o_cv), 32'(ev));
                check($sformatf("%s a=%0d multi_hot", nm, k - 1), 32'(o_mh), 32'(emh));
            end
            if (c < total && j <= s)
                check($sformatf("%s a=%0d WXYZ c=%0d", nm, k, j), 32'(o_addr), 32'(k));
            if (c < total && j == 0)
                check($sformatf("%s a=%0d busy", nm, k), 32'(o_busy), 32'h1);
            if (c == total + 1) begin
                check({nm, " done at scan end"}, 32'(o_done), 32'h1);
                check({nm, " busy at done"}, 32'(o_busy), 32'h0);
                check({nm, " WXYZ at done"}, 32'(o_addr), 32'h0);
                check({nm, " fault_map"}, 32'(o_fm), 32'(efm));
                check({nm, " fault_cnt"}, 32'(o_fc), 32'(efc));
            end
        end
        @(negedge clk);
        check({nm, " done one cycle"}, 32'(o_done), 32'h0);
        check({nm, " no requeued scan"}, 32'(o_busy), 32'h0);
        check({nm, " done pulse count"}, 32'(done_seen - base), 32'h1);
        check({nm, " fault_map held"}, 32'(o_fm), 32'(efm));
        check({nm, " fault_cnt held"}, 32'(o_fc), 32'(efc));
    endtask

    task automatic reset_mid_scan();
        int per, base;
        per = 4;
        base = done_seen;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r = 1'b0;
        for (int c = 1; c <= 7 * per + 1; c++) @(negedge clk);
        check("rst pre a=7", 32'(o_addr), 32'h7);
        check("rst pre busy", 32'(o_busy), 32'h1);
        check("rst pre code_valid", 32'(o_cv), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", 32'(o_busy), 32'h0);
        check("rst WXYZ", 32'(o_addr), 32'h0);
        check("rst done", 32'(o_done), 32'h0);
        check("rst code_out", 32'(o_co), 32'h0);
        check("rst code_valid", 32'(o_cv), 32'h0);
        check("rst multi_hot", 32'(o_mh), 32'h0);
        check("rst fault_map", 32'(o_fm), 32'h0);
        check("rst fault_cnt", 32'(o_fc), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst no done pulse", 32'(done_seen - base), 32'h0);
        check("rst stays idle", 32'(o_busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy", 32'(o_busy), 32'h0);
        check("reset done", 32'(o_done), 32'h0);
        check("reset WXYZ", 32'(o_addr), 32'h0);
        check("reset code_valid", 32'(o_cv), 32'h0);
        check("reset fault_cnt", 32'(o_fc), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sel = 2; mode = 0; run_scan(2, 0, 0, "good");
        mode = 1;          run_scan(2, 1, 0, "d0sa0");
        mode = 2;          run_scan(2, 2, 0, "d5sa1");
        mode = 0;          reset_mid_scan();
        run_scan(2, 0, 0, "after_rst");
        run_scan(2, 0, 1, "hold");
        run_scan(2, 0, 2, "pulse9");
        sel = 1;  run_scan(1, 0, 0, "s1");
        sel = 15; run_scan(15, 0, 0, "s15");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_16x4_scan.md
Name: enc_16x4_scan

Overview:
Self-test scanner and 16-to-4 encoder that sits on the far side of the team's 4x16 decoders, including the fault-injected variants. It steps through all 16 input codes on the decoder's W,X,Y,Z inputs and samples the 16-bit one-hot output. It encodes each sample back to 4 bits, compares it against the expected one-hot, and accumulates a per-line fault map and a fault count for the bench or the top-level status logic.

Parameters:
SETTLE_CYC, 2, cycles the code is held on W,X,Y,Z before D_in is sampled (legal 1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  scan request; sampled in IDLE only
D_in  input  16  one-hot output of decoder under test
W  output  1  code bit 3 (MSB) to decoder
X  output  1  code bit 2 to decoder
Y  output  1  code bit 1 to decoder
Z  output  1  code bit 0 to decoder
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse at scan end
code_out  output  4  encoded index of the last sampled D_in
code_valid  output  1  code_out is meaningful for the last sample
multi_hot  output  1  last sample had more than one bit set
fault_map  output  16  bit a set if address a produced D_in != (1<<a)
fault_cnt  output  5  number of faulty addresses, 0..16

Behaviour:
- Reset is asynchronous, active-low, one clock domain.
  - On reset, all outputs go to 0, the FSM goes to IDLE and the address counter goes to 0.
  - Reset mid-scan aborts the scan. No done pulse is issued.
- Address a is 4 bits and drives {W,X,Y,Z}=a, so W=a[3] and Z=a[0]. Expected decoder response is D_in == 16'h1 << a.
- FSM states: IDLE, DRIVE, SAMPLE, CHECK, FIN.
  - IDLE: busy=0. On start=1, clear fault_map, fault_cnt, code_valid and multi_hot; set a=0; go to DRIVE. busy=1 from the next cycle.
  - DRIVE: hold a on W,X,Y,Z for SETTLE_CYC cycles using a settle counter, then go to SAMPLE.
  - SAMPLE: register D_in into an internal capture register; go to CHECK.
  - CHECK, encoding of the captured value:
    - Exactly one bit set: code_out = index of that bit, code_valid=1, multi_hot=0.
    - Zero bits set: code_valid=0, multi_hot=0, code_out=0.
    - More than one bit set: multi_hot=1; code_out and code_valid follow the Optional Feature.
  - CHECK, fault recording: if the capture != expected, set fault_map[a] and increment fault_cnt.
  - CHECK, exit: if a==15, go to FIN; otherwise increment a and go to DRIVE.
  - FIN: done=1 for exactly one cycle, busy=0, W,X,Y,Z return to 0; go to IDLE.
- Cycles per address = SETTLE_CYC+2. Scan length from start acceptance to done = 16*(SETTLE_CYC+2)+1 cycles (65 with the default).
- start while busy is ignored; there is no queuing. start high in the FIN cycle is also ignored.
- fault_cnt cannot exceed 16. Its 5-bit width makes this exact and no wrap-around occurs.
- fault_map, fault_cnt, code_out, code_valid and multi_hot hold their values after done until the next accepted start or reset.

Optional Feature:
Macro ENC_PRIORITY_EN.
- Defined: a multi-hot sample is resolved by highest-index priority. code_out = index of the highest set bit and code_valid=1; multi_hot is still 1 and a fault is still recorded.
- Undefined: a multi-hot sample gives code_valid=0 and code_out=0.
- All other behaviour is identical with and without the macro.

Test Plan:
1. Fault-free decoder model, SETTLE_CYC=2, start pulsed -> done pulse 65 cycles after start acceptance; fault_map=16'h0000, fault_cnt=0; code_out tracks a (0..15) in each CHECK with code_valid=1.
2. D[0] stuck-at-0 model -> fault_map=16'h0001, fault_cnt=1; at a=0, code_valid=0 and multi_hot=0; at a=1..15, code_valid=1.
3. D[5] stuck-at-1 model -> fault_map=16'hFFDF, fault_cnt=15; multi_hot=1 at every a except 5. With ENC_PRIORITY_EN: at a=3, code_out=5 and code_valid=1. Without it: at a=3, code_valid=0.
4. rst_n low at a=7 during DRIVE -> all outputs are 0 immediately, asynchronously, with no done pulse. A new start after reset release completes a full 16-address scan.
5. start held high through the whole scan and pulsed again at a=9 -> exactly one scan and one done pulse. A second scan begins only once start is seen in IDLE.
6. Fault-free model with SETTLE_CYC=1 and SETTLE_CYC=15 -> scan lengths of 49 and 273 cycles; W,X,Y,Z are stable for the full settle window before each sample.
